// File: rtl/nrzi_pkg.sv
// Shared state encodings and constants for the NRZI transmitter.
// Imported by the transmitter top and its bit timer.
package nrzi_pkg;

  localparam logic S_IDLE    = 1'b0;
  localparam logic S_SHIFT   = 1'b1;
  localparam logic LINE_IDLE = 1'b0;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nrzi_bit_timer.sv
// Bit-period and bit-index counters for the NRZI transmitter.
// Flags the first and last cycle of each bit and of each word.
module nrzi_bit_timer
  import nrzi_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic bit_start,
  output logic bit_end,
  output logic last_cycle_of_word
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;

  assign bit_start = en && (clk_cnt == '0);
  assign bit_end   = en && (clk_cnt == CLK_LAST);
  assign last_cycle_of_word =
    bit_end && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      if (clk_cnt == CLK_LAST) begin
        clk_cnt <= '0;
        bit_cnt <= (bit_cnt == BIT_LAST) ?
                   '0 : bit_cnt + 1'b1;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nrzi_tx.sv
// NRZI serial transmitter: shifts words out LSB first and
// toggles the line for every '1' bit.
module nrzi_tx
  import nrzi_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_line,
  output logic              tx_bit_start,
  output logic              tx_active,
  output logic              tx_done
);

  logic              state;
  logic              state_nxt;
  logic [DATA_W-1:0] sh;
  logic              shifting;
  logic              accept;
  logic              bit_end;
  logic              last;

  assign shifting  = (state == S_SHIFT);
  assign din_ready = (state == S_IDLE) || last;
  assign accept    = din_valid && din_ready;
  assign tx_active = shifting;
  assign tx_done   = last;

  nrzi_bit_timer #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk               (clk),
    .rst               (rst),
    .start             (accept),
    .en                (shifting),
    .bit_start         (tx_bit_start),
    .bit_end           (bit_end),
    .last_cycle_of_word(last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (last && !accept) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The edge that ends one bit launches the next bit's toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh      <= '0;
      tx_line <= LINE_IDLE;
    end else if (accept) begin
      sh      <= din;
      tx_line <= tx_line ^ din[0];
    end else if (bit_end && !last) begin
      sh      <= sh >> 1;
      tx_line <= tx_line ^ sh[1];
    end
  end

endmodule

// File: tb/tb_nrzi_tx.sv
// Directed and loopback bench for nrzi_tx.
// Two instances: one bit per clock, and four clocks per bit.
module tb_nrzi_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       tx_line;
  logic       tx_bit_start;
  logic       tx_active;
  logic       tx_done;

  logic [7:0] din2;
  logic       din_valid2;
  logic       din_ready2;
  logic       tx_line2;
  logic       tx_bit_start2;
  logic       tx_active2;
  logic       tx_done2;

  int tests;
  int fails;

  nrzi_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .tx_line     (tx_line),
    .tx_bit_start(tx_bit_start),
    .tx_active   (tx_active),
    .tx_done     (tx_done)
  );

  nrzi_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .din         (din2),
    .din_valid   (din_valid2),
    .din_ready   (din_ready2),
    .tx_line     (tx_line2),
    .tx_bit_start(tx_bit_start2),
    .tx_active   (tx_active2),
    .tx_done     (tx_done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Receiver-side transition detector for the loopback test.
  logic       lb_on;
  logic       lb_prev;
  logic [7:0] lb_word;
  int         lb_cnt;
  logic [7:0] rec_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (lb_on && tx_bit_start) begin
      lb_word = {tx_line ^ lb_prev, lb_word[7:1]};
      lb_prev = tx_line;
      lb_cnt  = lb_cnt + 1;
      if (lb_cnt == 8) begin
        rec_q.push_back(lb_word);
        lb_cnt = 0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    din = '0; din_valid = 1'b0;
    din2 = '0; din_valid2 = 1'b0;
    #12;
    tests++;
    if ({tx_line, din_ready, tx_active, tx_bit_start, tx_done}
        !== 5'b01000) begin
      fails++;
      $display("FAIL reset_outs got %b want 01000",
        {tx_line, din_ready, tx_active, tx_bit_start, tx_done});
    end
    tests++;
    if ({tx_line2, din_ready2, tx_active2} !== 3'b010) begin
      fails++;
      $display("FAIL reset_outs4 got %b want 010",
        {tx_line2, din_ready2, tx_active2});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_a5();
    logic [7:0] exp_line;
    exp_line = 8'b0110_0011;
    @(posedge clk); #1;
    din = 8'hA5; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tests++;
      if (tx_line !== exp_line[c-1]) begin
        fails++;
        $display("FAIL a5_line c%0d got %b want %b",
          c, tx_line, exp_line[c-1]);
      end
      tests++;
      if (tx_done !== (c == 8) || din_ready !== (c == 8)) begin
        fails++;
        $display("FAIL a5_done_ready c%0d got %b%b want %b%b",
          c, tx_done, din_ready, c == 8, c == 8);
      end
    end
    @(negedge clk);
    tests++;
    if (din_ready !== 1'b1 || tx_active !== 1'b0 ||
        tx_line !== 1'b0) begin
      fails++;
      $display("FAIL a5_idle got rdy%b act%b line%b want 1 0 0",
        din_ready, tx_active, tx_line);
    end
  endtask

  task automatic test_00_ff();
    logic [7:0] exp_ff;
    exp_ff = 8'b0101_0101;
    @(posedge clk); #1;
    din = 8'h00; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tests++;
      if (tx_line !== 1'b0) begin
        fails++;
        $display("FAIL w00_line c%0d got %b want 0", c, tx_line);
      end
    end
    @(posedge clk); #1;
    din = 8'hFF; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tests++;
      if (tx_line !== exp_ff[c-1]) begin
        fails++;
        $display("FAIL wff_line c%0d got %b want %b",
          c, tx_line, exp_ff[c-1]);
      end
    end
    @(negedge clk);
    tests++;
    if (tx_line !== 1'b0) begin
      fails++;
      $display("FAIL wff_hold got %b want 0", tx_line);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    din = 8'h01; din_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'h80;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      tests++;
      if (tx_line !== (c < 16)) begin
        fails++;
        $display("FAIL b2b_line c%0d got %b want %b",
          c, tx_line, c < 16);
      end
      tests++;
      if (tx_done !== (c == 8 || c == 16)) begin
        fails++;
        $display("FAIL b2b_done c%0d got %b want %b",
          c, tx_done, c == 8 || c == 16);
      end
      if (c == 8) begin
        @(posedge clk); #1;
        din_valid = 1'b0;
      end
    end
    @(negedge clk);
    tests++;
    if (tx_active !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle got act %b want 0", tx_active);
    end
  endtask

  task automatic test_slow();
    @(posedge clk); #1;
    din2 = 8'h03; din_valid2 = 1'b1;
    @(posedge clk); #1;
    din_valid2 = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      tests++;
      if (tx_line2 !== (c <= 4)) begin
        fails++;
        $display("FAIL slow_line c%0d got %b want %b",
          c, tx_line2, c <= 4);
      end
      tests++;
      if (tx_bit_start2 !== ((c - 1) % 4 == 0)) begin
        fails++;
        $display("FAIL slow_bs c%0d got %b want %b",
          c, tx_bit_start2, (c - 1) % 4 == 0);
      end
      tests++;
      if (din_ready2 !== (c == 32) || tx_done2 !== (c == 32)) begin
        fails++;
        $display("FAIL slow_rdy c%0d got %b%b want %b%b",
          c, din_ready2, tx_done2, c == 32, c == 32);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    din = 8'hFF; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    tests++;
    if (tx_active !== 1'b1 || din_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_pre got act%b rdy%b want 1 0",
        tx_active, din_ready);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({tx_line, din_ready, tx_active, tx_done} !== 4'b0100) begin
      fails++;
      $display("FAIL mid_async got %b want 0100",
        {tx_line, din_ready, tx_active, tx_done});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    din = 8'h01; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tests++;
      if (tx_line !== 1'b1) begin
        fails++;
        $display("FAIL mid_after c%0d got %b want 1", c, tx_line);
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] w;
    int         wait_cnt;
    logic       got;
    @(negedge clk);
    rst = 1'b0;
    #2;
    lb_prev = 1'b0; lb_cnt = 0; lb_word = '0;
    rec_q.delete(); exp_q.delete();
    lb_on = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom);
      din = w; din_valid = 1'b1;
      got = 1'b0;
      wait_cnt = 0;
      while (!got && wait_cnt < 20) begin
        @(negedge clk);
        if (din_ready) got = 1'b1;
        wait_cnt++;
        @(posedge clk); #1;
      end
      if (!got) begin
        tests++; fails++;
        $display("FAIL lb_timeout word %0d", i);
        break;
      end
      exp_q.push_back(w);
      if ($urandom_range(0, 3) == 0) begin
        din_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    din_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    lb_on = 1'b0;
    tests++;
    if (rec_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL lb_count got %0d want %0d",
        rec_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
      tests++;
      if (rec_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL lb_word %0d got %h want %h",
          i, rec_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    lb_on = 1'b0;
    lb_prev = 1'b0;
    lb_cnt = 0;
    lb_word = '0;
    test_reset();
    test_a5();
    test_00_ff();
    test_back_to_back();
    test_slow();
    test_mid_reset();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
